// File: rtl/y_capture_checker.sv
// rtl/y_capture_checker.sv - settle-delayed bit-exact compare of DUT vs reference y with mismatch FIFO
module y_capture_checker #(
  parameter int WIDTH  = 117,
  parameter int SETTLE = 2,
  parameter int DEPTH  = 4,
  parameter int ID_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stim_valid,
  input  logic [ID_W-1:0]  stim_id,
  input  logic [WIDTH-1:0] y_dut,
  input  logic [WIDTH-1:0] y_ref,
  input  logic             rd_en,
  output logic             busy,
  output logic             mis_valid,
  output logic [ID_W-1:0]  mis_id,
  output logic [WIDTH-1:0] mis_diff,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow,
  output logic             dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [7:0] LOAD = 8'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CMP} state_t;

  state_t         state;
  state_t         first_state;
  logic [7:0]     cnt;
  logic [ID_W-1:0] cur_id;

  logic [ID_W-1:0]  fifo_id   [DEPTH];
  logic [WIDTH-1:0] fifo_diff [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;

  logic cmp_now, mismatch, full, push, push_ok, pop;

  assign first_state = (SETTLE == 1) ? CMP : WAIT;
  assign cmp_now  = (state == CMP);
  // case inequality so that X/Z on either side is reported as a mismatch
  assign mismatch = (y_dut !== y_ref);
  assign full     = (occ == FULL_OCC);
  assign push     = cmp_now && mismatch;
  assign pop      = rd_en && (occ != '0);
  assign push_ok  = push && (!full || pop);

  assign mis_valid = (occ != '0);
  assign mis_id    = mis_valid ? fifo_id[rd_ptr]   : '0;
  assign mis_diff  = mis_valid ? fifo_diff[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_id[wr_ptr]   <= cur_id;
      fifo_diff[wr_ptr] <= y_dut ^ y_ref;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_id    <= '0;
      busy      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      vec_count <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stim_valid) begin
            cur_id <= stim_id;
            cnt    <= LOAD;
            state  <= first_state;
            busy   <= 1'b1;
          end
        end
        WAIT: begin
          if (stim_valid) dropped <= 1'b1;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= CMP;
        end
        CMP: begin
          // the compare edge may also accept the next vector back-to-back
          if (stim_valid) begin
            cur_id <= stim_id;
            cnt    <= LOAD;
            state  <= first_state;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (cmp_now) begin
        if (vec_count != '1) vec_count <= vec_count + 1'b1;
        if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
      end

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
